// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART.
// Contents: oversampling constant, data-bit/parity/state enums, the RX FIFO word
// layout and small decode helpers for the frame format.
package uart_pkg;

  localparam int unsigned OVS    = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } par_mode_e;

  typedef enum logic [1:0] {
    DB_5 = 2'd0,
    DB_6 = 2'd1,
    DB_7 = 2'd2,
    DB_8 = 2'd3
  } data_bits_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  typedef struct packed {
    logic              frm_err;
    logic              par_err;
    logic [DATA_W-1:0] data;
  } rx_word_t;

  localparam int unsigned RX_WORD_W = $bits(rx_word_t);

  // Mask keeping only the configured number of data bits.
  function automatic logic [DATA_W-1:0] data_mask(data_bits_e db);
    return 8'hFF >> (2'd3 - 2'(db));
  endfunction

  // Index of the last data bit of a frame (4..7).
  function automatic logic [2:0] last_bit(data_bits_e db);
    return 3'd4 + 3'(db);
  endfunction

  function automatic logic has_parity(par_mode_e pm);
    return (pm == PAR_EVEN) || (pm == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_cfg_if.sv
// Bus-side handshake bundle of the UART.
// master: register/peripheral logic (pushes TX bytes, pops RX words).
// slave:  the UART core.
interface uart_cfg_if;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       tx_full;
  logic       tx_busy;
  logic       rd_uart;
  logic [7:0] r_data;
  logic       r_par_err;
  logic       r_frm_err;
  logic       rx_empty;
  logic       rx_overrun;
  logic       clr_overrun;

  modport master (
    output wr_uart, w_data, rd_uart, clr_overrun,
    input  tx_full, tx_busy, r_data, r_par_err, r_frm_err, rx_empty, rx_overrun
  );

  modport slave (
    input  wr_uart, w_data, rd_uart, clr_overrun,
    output tx_full, tx_busy, r_data, r_par_err, r_frm_err, rx_empty, rx_overrun
  );
endinterface

// File: rtl/fifo.sv
// Register-based FIFO, 2**W entries of B bits, head visible with no read latency.
// Ports: clk, reset (async high), rd/wr strobes, w_data in; empty, full, r_data out.
// Push when full and pop when empty are ignored.
module fifo #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic         empty,
  output logic         full,
  output logic [B-1:0] r_data
);

  localparam int unsigned DEPTH = 2 ** W;

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic         full_n, empty_n;
  logic         wr_en, rd_en;

  assign wr_en  = wr & ~full;
  assign rd_en  = rd & ~empty;
  assign r_data = mem[rd_ptr];

  // Storage is not reset; the empty flag guards its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      full   <= full_n;
      empty  <= empty_n;
    end
  end

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    full_n   = full;
    empty_n  = empty;
    case ({wr_en, rd_en})
      2'b01: begin
        rd_ptr_n = rd_ptr + W'(1);
        full_n   = 1'b0;
        empty_n  = (rd_ptr + W'(1)) == wr_ptr;
      end
      2'b10: begin
        wr_ptr_n = wr_ptr + W'(1);
        empty_n  = 1'b0;
        full_n   = (wr_ptr + W'(1)) == rd_ptr;
      end
      2'b11: begin
        wr_ptr_n = wr_ptr + W'(1);
        rd_ptr_n = rd_ptr + W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_rx_par.sv
// UART receiver with parity and framing check.
// Ports: clk, reset (async high), tick (16x baud), rx pin, data_bits/par_mode config;
// done pulses for one clock with word = {frm_err, par_err, data zero-extended}.
// Only the first stop bit is checked.
module uart_rx_par
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx,
  input  logic [1:0] data_bits,
  input  logic [1:0] par_mode,
  output logic       done,
  output rx_word_t   word
);

  uart_state_e state, state_n;
  logic [3:0]  s, s_n;
  logic [2:0]  n, n_n;
  logic [7:0]  sh, sh_n;
  logic        par_acc, par_acc_n;
  logic        par_err, par_err_n;
  data_bits_e  db, db_n;
  par_mode_e   pm, pm_n;
  logic        done_n;
  rx_word_t    word_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      s       <= '0;
      n       <= '0;
      sh      <= '0;
      par_acc <= 1'b0;
      par_err <= 1'b0;
      db      <= DB_8;
      pm      <= PAR_NONE;
      done    <= 1'b0;
      word    <= '0;
    end else begin
      state   <= state_n;
      s       <= s_n;
      n       <= n_n;
      sh      <= sh_n;
      par_acc <= par_acc_n;
      par_err <= par_err_n;
      db      <= db_n;
      pm      <= pm_n;
      done    <= done_n;
      word    <= word_n;
    end
  end

  always_comb begin
    state_n   = state;
    s_n       = s;
    n_n       = n;
    sh_n      = sh;
    par_acc_n = par_acc;
    par_err_n = par_err;
    db_n      = db;
    pm_n      = pm;
    done_n    = 1'b0;
    word_n    = word;
    case (state)
      ST_IDLE: begin
        if (!rx) begin
          state_n = ST_START;
          s_n     = '0;
        end
      end
      // Mid start bit: still low confirms a frame, high means it was a glitch.
      ST_START: begin
        if (tick) begin
          if (s == 4'(OVS / 2 - 1)) begin
            if (rx) begin
              state_n = ST_IDLE;
            end else begin
              state_n   = ST_DATA;
              s_n       = '0;
              n_n       = '0;
              par_acc_n = 1'b0;
              par_err_n = 1'b0;
              db_n      = data_bits_e'(data_bits);
              pm_n      = par_mode_e'(par_mode);
            end
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      // Bits enter at the MSB; the word is right-aligned when pushed.
      ST_DATA: begin
        if (tick) begin
          if (s == 4'(OVS - 1)) begin
            s_n       = '0;
            sh_n      = {rx, sh[7:1]};
            par_acc_n = par_acc ^ rx;
            if (n == last_bit(db)) begin
              state_n = has_parity(pm) ? ST_PARITY : ST_STOP;
            end else begin
              n_n = n + 3'd1;
            end
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (s == 4'(OVS - 1)) begin
            s_n       = '0;
            par_err_n = (pm == PAR_ODD) ? ~(par_acc ^ rx) : (par_acc ^ rx);
            state_n   = ST_STOP;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (s == 4'(OVS - 1)) begin
            done_n         = 1'b1;
            word_n.frm_err = ~rx;
            word_n.par_err = par_err;
            word_n.data    = sh >> (2'd3 - 2'(db));
            state_n        = ST_IDLE;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cfg_top.sv
// Runtime-configurable UART core: baud generator, TX FSM, RX with error flags, FIFOs.
// Ports: clk, reset (async high), dvsr/data_bits/par_mode/stop_bits config,
// rx/tx serial pins, bus (uart_cfg_if.slave) for TX push / RX pop / status.
module uart_cfg_top
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_W = 2,
  parameter int unsigned DVSR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        data_bits,
  input  logic [1:0]        par_mode,
  input  logic              stop_bits,
  input  logic              rx,
  output logic              tx,
  uart_cfg_if.slave         bus
);

  // Baud tick generator; the divisor is reloaded only when the counter wraps.
  logic [DVSR_W-1:0] baud_cnt, dvsr_q;
  logic              tick;

  assign tick = (baud_cnt >= dvsr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      dvsr_q   <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
      dvsr_q   <= dvsr;
    end else begin
      baud_cnt <= baud_cnt + DVSR_W'(1);
    end
  end

  // TX FIFO
  logic       tx_pop, tx_empty, tx_full_i;
  logic [7:0] tx_head;

  fifo #(.B(DATA_W), .W(FIFO_W)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .rd     (tx_pop),
    .wr     (bus.wr_uart),
    .w_data (bus.w_data),
    .empty  (tx_empty),
    .full   (tx_full_i),
    .r_data (tx_head)
  );

  assign bus.tx_full = tx_full_i;

  // TX FSM
  uart_state_e tx_state, tx_state_n;
  logic [4:0]  tx_s, tx_s_n;
  logic [2:0]  tx_n, tx_n_n;
  logic [7:0]  tx_sh, tx_sh_n, tx_masked;
  logic        tx_par, tx_par_n;
  data_bits_e  tx_db, tx_db_n;
  par_mode_e   tx_pm, tx_pm_n;
  logic        tx_two, tx_two_n;
  logic        tx_load, tx_out_n, busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_db    <= DB_8;
      tx_pm    <= PAR_NONE;
      tx_two   <= 1'b0;
      tx       <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_s     <= tx_s_n;
      tx_n     <= tx_n_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx_db    <= tx_db_n;
      tx_pm    <= tx_pm_n;
      tx_two   <= tx_two_n;
      tx       <= tx_out_n;
      busy_q   <= (tx_state_n != ST_IDLE) || !tx_empty || (bus.wr_uart && !tx_full_i);
    end
  end

  assign bus.tx_busy = busy_q;

  always_comb begin
    tx_state_n = tx_state;
    tx_s_n     = tx_s;
    tx_n_n     = tx_n;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_db_n    = tx_db;
    tx_pm_n    = tx_pm;
    tx_two_n   = tx_two;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    tx_out_n   = 1'b1;
    tx_masked  = tx_head & data_mask(data_bits_e'(data_bits));
    case (tx_state)
      ST_IDLE: begin
        if (!tx_empty) tx_load = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          if (tx_s == 5'(OVS - 1)) begin
            tx_s_n     = '0;
            tx_n_n     = '0;
            tx_state_n = ST_DATA;
          end else begin
            tx_s_n = tx_s + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tx_s == 5'(OVS - 1)) begin
            tx_s_n  = '0;
            tx_sh_n = tx_sh >> 1;
            if (tx_n == last_bit(tx_db)) begin
              tx_state_n = has_parity(tx_pm) ? ST_PARITY : ST_STOP;
            end else begin
              tx_n_n = tx_n + 3'd1;
            end
          end else begin
            tx_s_n = tx_s + 5'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (tx_s == 5'(OVS - 1)) begin
            tx_s_n     = '0;
            tx_state_n = ST_STOP;
          end else begin
            tx_s_n = tx_s + 5'd1;
          end
        end
      end
      // End of stop: chain straight into the next queued byte with no idle gap.
      ST_STOP: begin
        if (tick) begin
          if (tx_s == (tx_two ? 5'(2 * OVS - 1) : 5'(OVS - 1))) begin
            if (!tx_empty) tx_load = 1'b1;
            else           tx_state_n = ST_IDLE;
          end else begin
            tx_s_n = tx_s + 5'd1;
          end
        end
      end
      default: tx_state_n = ST_IDLE;
    endcase

    // Pop the head and latch the frame format for the whole frame.
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_sh_n    = tx_masked;
      tx_par_n   = (^tx_masked) ^ (par_mode_e'(par_mode) == PAR_ODD);
      tx_db_n    = data_bits_e'(data_bits);
      tx_pm_n    = par_mode_e'(par_mode);
      tx_two_n   = stop_bits;
      tx_s_n     = '0;
      tx_state_n = ST_START;
    end

    // Line level follows the state being entered so tx lines up with the FSM.
    case (tx_state_n)
      ST_START:  tx_out_n = 1'b0;
      ST_DATA:   tx_out_n = tx_sh_n[0];
      ST_PARITY: tx_out_n = tx_par_n;
      default:   tx_out_n = 1'b1;
    endcase
  end

  // RX path
  logic     rx_done, rx_empty_i, rx_full;
  rx_word_t rx_word, rx_head;

  uart_rx_par u_rx (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .rx        (rx),
    .data_bits (data_bits),
    .par_mode  (par_mode),
    .done      (rx_done),
    .word      (rx_word)
  );

  fifo #(.B(RX_WORD_W), .W(FIFO_W)) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .rd     (bus.rd_uart),
    .wr     (rx_done),
    .w_data (rx_word),
    .empty  (rx_empty_i),
    .full   (rx_full),
    .r_data (rx_head)
  );

  // Head fields read as zero while empty so reset shows r_* = 0.
  assign bus.rx_empty  = rx_empty_i;
  assign bus.r_data    = rx_empty_i ? '0 : rx_head.data;
  assign bus.r_par_err = rx_empty_i ? 1'b0 : rx_head.par_err;
  assign bus.r_frm_err = rx_empty_i ? 1'b0 : rx_head.frm_err;

  // Sticky overrun; a new overrun wins over a same-cycle clear.
  logic overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   overrun_q <= 1'b0;
    else if (rx_done && rx_full) overrun_q <= 1'b1;
    else if (bus.clr_overrun)    overrun_q <= 1'b0;
  end

  assign bus.rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_cfg_top.sv
// Self-checking bench for uart_cfg_top: directed frames plus randomized loopback
// and error-injection frames, checked against a queue-based model of the RX FIFO
// and a bit-list model of the serial frame.
module tb_uart_cfg_top;

  localparam int unsigned FIFO_W = 2;
  localparam int unsigned DVSR_W = 11;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DVSR_W-1:0] dvsr;
  logic [1:0]        data_bits, par_mode;
  logic              stop_bits;
  logic              rx_bit, loop, rx_line, tx;

  uart_cfg_if bus();

  assign rx_line = loop ? tx : rx_bit;

  uart_cfg_top #(.FIFO_W(FIFO_W), .DVSR_W(DVSR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .dvsr      (dvsr),
    .data_bits (data_bits),
    .par_mode  (par_mode),
    .stop_bits (stop_bits),
    .rx        (rx_line),
    .tx        (tx),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          p        = 4;
  logic [9:0]  mdl_q[$];
  bit          mdl_ovr  = 1'b0;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int d, input int db, input int pm, input int sb);
    @(negedge clk);
    dvsr      = DVSR_W'(d);
    data_bits = 2'(db);
    par_mode  = 2'(pm);
    stop_bits = 1'(sb);
    p         = d + 1;
    repeat (16) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] v);
    @(negedge clk);
    bus.wr_uart = 1'b1;
    bus.w_data  = v;
    @(negedge clk);
    bus.wr_uart = 1'b0;
  endtask

  // Expected frame: 0, n data bits LSB first, optional parity, 1 or 2 stop bits.
  task automatic tx_frame(input string tag, input int v, input int db, input int pm, input int sb);
    int nb, val, ones, t;
    nb   = db + 5;
    val  = v % (1 << nb);
    ones = 0;
    t    = 0;
    while (tx !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (8 * p) @(negedge clk);
    check({tag, "_start"}, 10'(tx), 10'd0);
    for (int i = 0; i < nb; i++) begin
      repeat (16 * p) @(negedge clk);
      check($sformatf("%s_d%0d", tag, i), 10'(tx), 10'((val >> i) & 1));
      ones += (val >> i) & 1;
    end
    if (pm == 1 || pm == 2) begin
      repeat (16 * p) @(negedge clk);
      check({tag, "_par"}, 10'(tx), 10'((ones % 2) ^ (pm == 2 ? 1 : 0)));
    end
    repeat (16 * p) @(negedge clk);
    check({tag, "_stop"}, 10'(tx), 10'd1);
    if (sb != 0) begin
      repeat (16 * p) @(negedge clk);
      check({tag, "_stop2"}, 10'(tx), 10'd1);
    end
  endtask

  task automatic model_push(input logic [9:0] w);
    if (mdl_q.size() == DEPTH) mdl_ovr = 1'b1;
    else                       mdl_q.push_back(w);
  endtask

  // Drive one frame onto rx; a bad stop is held low only long enough to be sampled.
  task automatic drive_rx(input int v, input int db, input int pm, input bit bad_par, input bit bad_stop);
    int nb, ones;
    bit has_par;
    nb      = db + 5;
    ones    = 0;
    has_par = (pm == 1 || pm == 2);
    @(negedge clk);
    rx_bit = 1'b0;
    repeat (16 * p) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx_bit = 1'((v >> i) & 1);
      ones  += (v >> i) & 1;
      repeat (16 * p) @(negedge clk);
    end
    if (has_par) begin
      rx_bit = 1'((ones % 2) ^ (pm == 2 ? 1 : 0)) ^ bad_par;
      repeat (16 * p) @(negedge clk);
    end
    if (bad_stop) begin
      rx_bit = 1'b0;
      repeat (12 * p) @(negedge clk);
      rx_bit = 1'b1;
      repeat (4 * p) @(negedge clk);
    end else begin
      rx_bit = 1'b1;
      repeat (16 * p) @(negedge clk);
    end
    repeat (8 * p) @(negedge clk);
    model_push({bad_stop, bad_par & has_par, 8'(v % (1 << nb))});
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    e = mdl_q.pop_front();
    check({tag, "_empty"}, 10'(bus.rx_empty), 10'd0);
    check({tag, "_data"}, 10'(bus.r_data), 10'(e[7:0]));
    check({tag, "_perr"}, 10'(bus.r_par_err), 10'(e[8]));
    check({tag, "_ferr"}, 10'(bus.r_frm_err), 10'(e[9]));
    @(negedge clk);
    bus.rd_uart = 1'b1;
    @(negedge clk);
    bus.rd_uart = 1'b0;
  endtask

  initial begin
    logic [7:0] vals [6];
    int d, db, pm, sb, v;
    bit bp, bs;

    reset = 1'b1; rx_bit = 1'b1; loop = 1'b0;
    bus.wr_uart = 1'b0; bus.w_data = '0; bus.rd_uart = 1'b0; bus.clr_overrun = 1'b0;
    dvsr = DVSR_W'(3); data_bits = 2'd3; par_mode = 2'd0; stop_bits = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_tx",      10'(tx),             10'd1);
    check("rst_busy",    10'(bus.tx_busy),    10'd0);
    check("rst_full",    10'(bus.tx_full),    10'd0);
    check("rst_rxempty", 10'(bus.rx_empty),   10'd1);
    check("rst_ovr",     10'(bus.rx_overrun), 10'd0);
    check("rst_rdata",   10'(bus.r_data),     10'd0);
    check("rst_perr",    10'(bus.r_par_err),  10'd0);
    check("rst_ferr",    10'(bus.r_frm_err),  10'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // 8N1 0xA5 with busy dropping after the stop bit
    set_cfg(3, 3, 0, 0);
    write_tx(8'hA5);
    tx_frame("a5", 'hA5, 3, 0, 0);
    check("a5_busy_stop", 10'(bus.tx_busy), 10'd1);
    repeat (10 * p) @(negedge clk);
    check("a5_busy_end", 10'(bus.tx_busy), 10'd0);
    check("a5_idle", 10'(tx), 10'd1);

    // 7E2 loopback
    set_cfg(3, 2, 1, 1);
    loop = 1'b1;
    write_tx(8'h55);
    write_tx(8'h7F);
    tx_frame("e2a", 'h55, 2, 1, 1);
    model_push({2'b00, 8'h55});
    tx_frame("e2b", 'h7F, 2, 1, 1);
    model_push({2'b00, 8'h7F});
    repeat (16 * p) @(negedge clk);
    loop = 1'b0;
    pop_check("e2a_rx");
    pop_check("e2b_rx");
    check("e2_drained", 10'(bus.rx_empty), 10'd1);

    // 8O1 bad parity, then bad stop
    set_cfg(3, 3, 2, 0);
    drive_rx('h3C, 3, 2, 1'b1, 1'b0);
    drive_rx('hC3, 3, 2, 1'b0, 1'b1);
    pop_check("o1_par");
    pop_check("o1_frm");

    // Overrun: five frames with no reads
    set_cfg(1, 3, 0, 0);
    for (int i = 0; i < 5; i++) drive_rx(int'($urandom_range(0, 255)), 3, 0, 1'b0, 1'b0);
    check("ovr_set", 10'(bus.rx_overrun), 10'(mdl_ovr));
    @(negedge clk); bus.clr_overrun = 1'b1;
    @(negedge clk); bus.clr_overrun = 1'b0;
    mdl_ovr = 1'b0;
    check("ovr_clr", 10'(bus.rx_overrun), 10'd0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovr_w%0d", i));
    check("ovr_drained", 10'(bus.rx_empty), 10'd1);

    // Start-bit glitch of three ticks, then a good frame
    @(negedge clk); rx_bit = 1'b0;
    repeat (3 * p) @(negedge clk);
    rx_bit = 1'b1;
    repeat (32 * p) @(negedge clk);
    check("glitch_empty", 10'(bus.rx_empty), 10'd1);
    drive_rx('h96, 3, 0, 1'b0, 1'b0);
    pop_check("glitch_after");

    // TX FIFO full: six back-to-back writes, the last one is dropped
    set_cfg(3, 3, 0, 0);
    for (int i = 0; i < 6; i++) begin
      vals[i] = 8'($urandom_range(0, 255));
      @(negedge clk);
      bus.wr_uart = 1'b1;
      bus.w_data  = vals[i];
    end
    @(negedge clk);
    bus.wr_uart = 1'b0;
    check("txf_full", 10'(bus.tx_full), 10'd1);
    for (int i = 0; i < 5; i++) tx_frame($sformatf("txf%0d", i), int'(vals[i]), 3, 0, 0);
    repeat (10 * p) @(negedge clk);
    check("txf_drop", 10'(bus.tx_busy), 10'd0);

    // Reset mid-frame with both FIFOs holding data
    drive_rx('h11, 3, 0, 1'b0, 1'b0);
    write_tx(8'h00);
    write_tx(8'h12);
    write_tx(8'h34);
    repeat (24 * p) @(negedge clk);
    check("mid_tx_low", 10'(tx), 10'd0);
    reset = 1'b1;
    #1;
    mdl_q.delete();
    mdl_ovr = 1'b0;
    check("mid_rst_tx",      10'(tx),           10'd1);
    check("mid_rst_busy",    10'(bus.tx_busy),  10'd0);
    check("mid_rst_rxempty", 10'(bus.rx_empty), 10'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40 * p) @(negedge clk);
    check("mid_after_tx",   10'(tx),          10'd1);
    check("mid_after_busy", 10'(bus.tx_busy), 10'd0);

    // Random loopback frames
    for (int k = 0; k < 6; k++) begin
      d  = int'($urandom_range(0, 3));
      db = int'($urandom_range(0, 3));
      pm = int'($urandom_range(0, 3));
      sb = int'($urandom_range(0, 1));
      v  = int'($urandom_range(0, 255));
      set_cfg(d, db, pm, sb);
      loop = 1'b1;
      write_tx(8'(v));
      tx_frame($sformatf("rl%0d", k), v, db, pm, sb);
      model_push({2'b00, 8'(v % (1 << (db + 5)))});
      repeat (16 * p) @(negedge clk);
      loop = 1'b0;
      pop_check($sformatf("rl%0d_rx", k));
    end

    // Random rx frames with error injection
    for (int k = 0; k < 6; k++) begin
      d  = int'($urandom_range(0, 3));
      db = int'($urandom_range(0, 3));
      pm = int'($urandom_range(0, 3));
      v  = int'($urandom_range(0, 255));
      bp = 1'($urandom_range(0, 1));
      bs = 1'($urandom_range(0, 1));
      set_cfg(d, db, pm, 0);
      drive_rx(v, db, pm, bp, bs);
      pop_check($sformatf("re%0d", k));
    end
    check("final_empty", 10'(bus.rx_empty), 10'd1);
    check("final_ovr", 10'(bus.rx_overrun), 10'(mdl_ovr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
